// File: rtl/counter_pkg.sv
// Shared counter definitions: the timer FSM state encoding.
package counter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/down_timer.sv
// Loadable down-counter with one-shot / periodic modes and a registered
// terminal-count pulse on each RUN-originated 1->0 transition.
module down_timer
  import counter_pkg::*;
#(
  parameter int Data_Width = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic                  ld,
  input  logic [Data_Width-1:0] datain,
  input  logic                  auto_reload,
  output logic [Data_Width-1:0] dataout,
  output logic                  tc,
  output logic                  busy,
  output logic                  done
);

  state_e                state_q, state_d;
  logic [Data_Width-1:0] dataout_q, dataout_d;
  logic [Data_Width-1:0] reload_q, reload_d;
  logic                  tc_q, tc_d;

  always_comb begin
    state_d   = state_q;
    dataout_d = dataout_q;
    reload_d  = reload_q;
    tc_d      = 1'b0;

    if (ld) begin
      dataout_d = datain;
      reload_d  = datain;
      state_d   = (datain != '0) ? RUN : IDLE;
    end else if (state_q == RUN && en) begin
      if (dataout_q == Data_Width'(1)) begin
        dataout_d = '0;
        tc_d      = 1'b1;
        if (!auto_reload) state_d = DONE;
      end else if (dataout_q == '0) begin
        // Zero is only held in RUN in periodic mode; spend one cycle reloading.
        dataout_d = reload_q;
      end else begin
        dataout_d = dataout_q - Data_Width'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      dataout_q <= '0;
      reload_q  <= '0;
      tc_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      dataout_q <= dataout_d;
      reload_q  <= reload_d;
      tc_q      <= tc_d;
    end
  end

  assign dataout = dataout_q;
  assign tc      = tc_q;
  assign busy    = (state_q == RUN);
  assign done    = (state_q == DONE);

endmodule

// File: tb/tb_down_timer.sv
// Scoreboard bench for down_timer: directed scenarios plus random traffic
// checked against a behavioural timer model.
module tb_down_timer;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         en = 1'b0;
  logic         ld = 1'b0;
  logic [W-1:0] datain = '0;
  logic         auto_reload = 1'b0;
  logic [W-1:0] dataout;
  logic         tc, busy, done;

  down_timer #(.Data_Width(W)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .en          (en),
    .ld          (ld),
    .datain      (datain),
    .auto_reload (auto_reload),
    .dataout     (dataout),
    .tc          (tc),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [W-1:0] cnt;
    logic         tc;
    logic         busy;
    logic         done;
  } exp_t;

  exp_t  expq[$];
  string tagq[$];
  string cur_tag = "reset";

  int n_vec = 0;
  int n_err = 0;

  // Behavioural reference: the timer is "running", "finished" or neither.
  logic [W-1:0] m_cnt = '0;
  logic [W-1:0] m_rel = '0;
  logic         m_running = 1'b0;
  logic         m_finished = 1'b0;
  logic         m_tc = 1'b0;

  task automatic model_reset();
    m_cnt = '0; m_rel = '0; m_running = 1'b0; m_finished = 1'b0; m_tc = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic e, input logic l,
                            input logic [W-1:0] d, input logic ar);
    m_tc = 1'b0;
    if (!r) begin
      model_reset();
    end else if (l) begin
      m_cnt = d;
      m_rel = d;
      m_running = (d != 0);
      m_finished = 1'b0;
    end else if (m_running && e) begin
      if (m_cnt == 0) begin
        m_cnt = m_rel;
      end else begin
        m_cnt = m_cnt - 1;
        if (m_cnt == 0) begin
          m_tc = 1'b1;
          if (!ar) begin
            m_running = 1'b0;
            m_finished = 1'b1;
          end
        end
      end
    end
  endtask

  // One clock of stimulus: drive away from the edge, predict, enqueue.
  task automatic step(input logic r, input logic e, input logic l,
                      input logic [W-1:0] d, input logic ar);
    exp_t x;
    @(negedge clk);
    rst_n = r; en = e; ld = l; datain = d; auto_reload = ar;
    model_step(r, e, l, d, ar);
    x.cnt = m_cnt; x.tc = m_tc; x.busy = m_running; x.done = m_finished;
    expq.push_back(x);
    tagq.push_back(cur_tag);
  endtask

  task automatic check_now(input string name, input exp_t x);
    n_vec++;
    if (dataout !== x.cnt || tc !== x.tc || busy !== x.busy || done !== x.done) begin
      n_err++;
      $display("FAIL %s: got dataout=%0d tc=%b busy=%b done=%b, want dataout=%0d tc=%b busy=%b done=%b",
               name, dataout, tc, busy, done, x.cnt, x.tc, x.busy, x.done);
    end
  endtask

  logic prev_tc = 1'b0;

  initial begin : monitor
    exp_t  x;
    string t;
    forever begin
      @(posedge clk);
      #1;
      if (expq.size() > 0) begin
        x = expq.pop_front();
        t = tagq.pop_front();
        check_now(t, x);
        if (prev_tc && tc) begin
          n_err++;
          $display("FAIL %s tc_back_to_back: got tc=1 twice, want a single-cycle pulse", t);
        end
        prev_tc = tc;
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish, want $finish before time limit");
    $fatal(1, "timeout");
  end

  initial begin : stim
    exp_t zero;
    zero = '0;

    // Reset state
    cur_tag = "reset_hold";
    repeat (3) step(1'b0, 1'b1, 1'b1, 8'd7, 1'b0);
    cur_tag = "idle_after_reset";
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // Async reset mid-RUN at count 3
    cur_tag = "reset_midrun";
    step(1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
    repeat (2) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_now("reset_async_immediate", zero);
    model_reset();
    cur_tag = "reset_release_idle";
    step(1'b0, 1'b1, 1'b0, 8'd0, 1'b0);
    repeat (4) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // One-shot of 5, then 10 more enabled cycles holding 0 in DONE
    cur_tag = "oneshot5";
    step(1'b1, 1'b0, 1'b1, 8'd5, 1'b0);
    repeat (15) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // Periodic reload 3
    cur_tag = "periodic3";
    step(1'b1, 1'b0, 1'b1, 8'd3, 1'b1);
    repeat (12) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);

    // Pause
    cur_tag = "pause4";
    step(1'b1, 1'b0, 1'b1, 8'd4, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // ld wins over the 1->0 transition
    cur_tag = "ld_priority";
    step(1'b1, 1'b1, 1'b1, 8'd2, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'd9, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // Zero load from DONE, then full-scale count
    cur_tag = "zero_load";
    step(1'b1, 1'b0, 1'b1, 8'd1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    step(1'b1, 1'b1, 1'b1, 8'd0, 1'b0);
    repeat (3) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);
    cur_tag = "full_scale";
    step(1'b1, 1'b0, 1'b1, 8'd255, 1'b0);
    repeat (260) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // Mode change mid-count
    cur_tag = "mode_switch";
    step(1'b1, 1'b0, 1'b1, 8'd4, 1'b1);
    repeat (6) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b1);
    repeat (8) step(1'b1, 1'b1, 1'b0, 8'd0, 1'b0);

    // Random traffic
    cur_tag = "random";
    for (int i = 0; i < 3000; i++) begin
      logic r, e, l, ar;
      logic [W-1:0] d;
      r  = ($urandom_range(0, 199) != 0);
      e  = ($urandom_range(0, 3) != 0);
      l  = ($urandom_range(0, 19) == 0);
      ar = ($urandom_range(0, 1) == 1);
      d  = ($urandom_range(0, 3) == 0) ? W'($urandom_range(0, 255)) : W'($urandom_range(0, 6));
      step(r, e, l, d, ar);
    end

    // Drain scoreboard
    for (int k = 0; k < 10 && expq.size() > 0; k++) @(posedge clk);
    #2;
    if (expq.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d entries left, want 0", expq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/down_timer.md
DOWN_TIMER -- requirements
Module: down_timer

Interface
REQ-001 The module SHALL have parameter Data_Width, default 8, the width of the count, load and reload values.
REQ-002 The port clk SHALL be an input of 1 bit and be the single clock; all state SHALL update on its rising edge.
REQ-003 The port rst_n SHALL be an input of 1 bit, an asynchronous active-low reset.
REQ-004 The port en SHALL be an input of 1 bit, the count enable, sampled at the rising edge.
REQ-005 The port ld SHALL be an input of 1 bit, the load strobe, sampled at the rising edge.
REQ-006 The port datain SHALL be an input of Data_Width bits, the load value.
REQ-007 The port auto_reload SHALL be an input of 1 bit, where 1 selects periodic mode and 0 selects one-shot mode, sampled at each count-reaching-zero event.
REQ-008 The port dataout SHALL be an output of Data_Width bits carrying the current count, registered.
REQ-009 The port tc SHALL be an output of 1 bit, the terminal-count pulse, registered.
REQ-010 The port busy SHALL be an output of 1 bit, high while the state is RUN.
REQ-011 The port done SHALL be an output of 1 bit, high while the state is DONE.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, RUN and DONE.
REQ-013 ld SHALL take priority over en in every state.
REQ-014 On ld=1 with datain!=0, the block SHALL set dataout<=datain and reload<=datain, enter RUN and force tc<=0.
REQ-015 On ld=1 with datain==0, the block SHALL set dataout<=0 and reload<=0, enter IDLE and keep tc=0.
REQ-016 In RUN with en=1, ld=0 and dataout>1, the block SHALL decrement dataout by 1.
REQ-017 In RUN with en=1, ld=0 and dataout==1, the block SHALL set dataout<=0 and tc<=1 for exactly one cycle.
REQ-018 In the case of REQ-017 with auto_reload=0, the next state SHALL be DONE.
REQ-019 In the case of REQ-017 with auto_reload=1, the state SHALL remain RUN.
REQ-020 In RUN with dataout==0 (only reachable in periodic mode) and en=1, the block SHALL set dataout<=reload.
REQ-021 The periodic-mode period SHALL be reload+1 enabled cycles.
REQ-022 The one-shot-mode duration SHALL be the loaded value N enabled cycles from load to tc.
REQ-023 In RUN with en=0, the block SHALL hold dataout and keep tc=0.
REQ-024 In IDLE and DONE, en SHALL be ignored and dataout SHALL be held.
REQ-025 DONE SHALL be exited only by ld or reset.
REQ-026 tc SHALL never be high on two consecutive cycles.
REQ-027 tc SHALL never assert outside a RUN-originated transition to 0.
REQ-028 dataout SHALL never underflow or wrap below 0.
REQ-029 busy and done SHALL be Moore outputs decoded from the registered state.
REQ-030 busy and done SHALL never both be high.
REQ-031 A change of auto_reload mid-count SHALL take effect only at the next 1->0 event.

Reset
REQ-032 Asserting rst_n=0 SHALL immediately, without waiting for clk, clear the state to IDLE, dataout to 0, reload to 0 and tc to 0.
REQ-033 Given REQ-032, busy and done SHALL both be 0 while reset is asserted.
REQ-034 Reset asserted mid-count SHALL abort the count with no tc pulse.
REQ-035 After rst_n deasserts, the block SHALL remain in IDLE until ld.
REQ-036 Deassertion of rst_n SHALL be synchronous to clk at the integration level, and the block SHALL add no synchronizer.

Structure
REQ-037 The state enum typedef (IDLE, RUN, DONE) SHALL live in the shared package counter_pkg.
REQ-038 No other typedefs or constants SHALL be placed in counter_pkg.
REQ-039 Data_Width SHALL remain a module parameter, not a package constant.
REQ-040 No sub-module SHALL be used; the block SHALL consist of one sequential FSM/datapath process plus a next-state/output decode.

Verification
REQ-041 A reset scenario SHALL check: rst_n=0 mid-RUN at count 3 -> dataout=0, tc=0, busy=0, done=0 immediately, and IDLE after release.
REQ-042 A one-shot scenario SHALL check: ld with datain=5, then en=1 continuously -> dataout 5,4,3,2,1,0; tc high only in the cycle dataout==0; then done=1, busy=0, and dataout holds 0 for 10 further enabled cycles.
REQ-043 A periodic scenario SHALL check: auto_reload=1, ld with datain=3, en=1 for 12 cycles -> sequence 3,2,1,0,3,2,1,0,...; tc pulses every 4th cycle; busy stays 1.
REQ-044 A pause scenario SHALL check: ld with datain=4, en toggled 1,0,0,1 -> dataout 4,3,3,3,2; no tc.
REQ-045 A priority scenario SHALL check: ld with datain=9 asserted in the same cycle the count would go 1->0 -> dataout=9, tc=0, state RUN.
REQ-046 A zero-load scenario SHALL check: ld with datain=0 in DONE -> IDLE, dataout=0, done=0, no tc; Data_Width=8 ld with datain=255 counts down to 0 with no wrap.
